// File: rtl/eq_pkg.sv
// Shared types and helpers for the band-EQ mixing engine: FSM states,
// gain shift derivation and saturation limits.
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_VOL  = 2'd2,
    ST_DONE = 2'd3
  } eq_state_t;

  // Gain of 2^(POT_W-1) is unity, so the product is shifted back by POT_W-1.
  function automatic int gain_shift(input int pot_w);
    return pot_w - 1;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/eq_mul_shift.sv
// Signed sample times unsigned gain, floored back to sample scale.
// The result carries two guard bits so callers can detect clipping.
module eq_mul_shift
  import eq_pkg::*;
#(
  parameter int DW    = 16,
  parameter int POT_W = 12
) (
  input  logic signed [DW-1:0]    i_x,
  input  logic        [POT_W-1:0] i_gain,
  output logic signed [DW+1:0]    o_y
);

  localparam int FW = DW + POT_W + 1;
  localparam int SH = gain_shift(POT_W);

  logic signed [FW-1:0] w_x_ext;
  logic signed [FW-1:0] w_g_ext;
  logic signed [FW-1:0] w_full;

  assign w_x_ext = FW'(i_x);
  assign w_g_ext = $signed(FW'(i_gain));
  assign w_full  = w_x_ext * w_g_ext;
  // |x*g| < 2^(DW-1) * 2^POT_W, so after the shift DW+2 bits always suffice.
  assign o_y     = (DW+2)'(w_full >>> SH);

endmodule

// File: rtl/eq_mix_engine.sv
// Multi-channel band mixer: per-band gains summed per channel, then master
// volume, all through one shared multiplier; one product per cycle.
module eq_mix_engine
  import eq_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 5,
  parameter int DW        = 16,
  parameter int POT_W     = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              band_vld,
  input  logic [NUM_CH*NUM_BANDS*DW-1:0]    band_smpl,
  input  logic [NUM_BANDS*POT_W-1:0]        band_gain,
  input  logic [POT_W-1:0]                  vol_gain,
  output logic [NUM_CH*DW-1:0]              out_smpl,
  output logic                              out_vld,
  output logic                              out_sat,
  output logic                              busy,
  output logic                              overrun
);

  localparam int AW     = DW + 2 + $clog2(NUM_BANDS);
  localparam int PW     = DW + 2;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  localparam logic signed [AW-1:0] ACC_MAX = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] ACC_MIN = AW'(sat_min(DW));
  localparam logic signed [PW-1:0] PRD_MAX = PW'(sat_max(DW));
  localparam logic signed [PW-1:0] PRD_MIN = PW'(sat_min(DW));
  localparam logic signed [DW-1:0] OUT_MAX = DW'(sat_max(DW));
  localparam logic signed [DW-1:0] OUT_MIN = DW'(sat_min(DW));

  eq_state_t r_state;
  eq_state_t w_state_next;

  logic [CH_W-1:0]       r_ch;
  logic [BAND_W-1:0]     r_band;
  logic signed [AW-1:0]  r_acc;
  logic                  r_frame_sat;
  logic                  r_out_vld;
  logic                  r_out_sat;
  logic                  r_overrun;

  logic signed [DW-1:0]  w_smpl [NUM_CH][NUM_BANDS];
  logic signed [DW-1:0]  r_smpl [NUM_CH][NUM_BANDS];
  logic [POT_W-1:0]      w_gain [NUM_BANDS];
  logic [POT_W-1:0]      r_gain [NUM_BANDS];
  logic [POT_W-1:0]      r_vol;
  logic signed [DW-1:0]  r_hold [NUM_CH];
  logic signed [DW-1:0]  r_out  [NUM_CH];

  logic signed [DW-1:0]  w_mul_x;
  logic [POT_W-1:0]      w_mul_gain;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_prod_ext;
  logic signed [DW-1:0]  w_acc_sat;
  logic signed [DW-1:0]  w_vol_sat;
  logic                  w_acc_clip;
  logic                  w_prod_clip;
  logic                  w_start;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    for (genvar gj = 0; gj < NUM_BANDS; gj++) begin : g_band
      assign w_smpl[gi][gj] = band_smpl[(gi*NUM_BANDS+gj)*DW +: DW];
    end
    assign out_smpl[gi*DW +: DW] = r_out[gi];
  end

  for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_gain
    assign w_gain[gi] = band_gain[gi*POT_W +: POT_W];
  end

  assign w_start = band_vld && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (band_vld) w_state_next = ST_MAC;
      ST_MAC:  if (r_band == LAST_BAND) w_state_next = ST_VOL;
      ST_VOL:  w_state_next = (r_ch == LAST_CH) ? ST_DONE : ST_MAC;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Frame snapshot: only read after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_smpl <= w_smpl;
      r_gain <= w_gain;
      r_vol  <= vol_gain;
    end
  end

  // VOL reuses the multiplier with the clipped channel sum as its operand.
  always_comb begin
    if (r_state == ST_VOL) begin
      w_mul_x    = w_acc_sat;
      w_mul_gain = r_vol;
    end else begin
      w_mul_x    = r_smpl[r_ch][r_band];
      w_mul_gain = r_gain[r_band];
    end
  end

  eq_mul_shift #(
    .DW    (DW),
    .POT_W (POT_W)
  ) u_mul (
    .i_x    (w_mul_x),
    .i_gain (w_mul_gain),
    .o_y    (w_prod)
  );

  assign w_prod_ext = AW'(w_prod);

  always_comb begin
    w_acc_clip = 1'b1;
    if (r_acc > ACC_MAX) begin
      w_acc_sat = OUT_MAX;
    end else if (r_acc < ACC_MIN) begin
      w_acc_sat = OUT_MIN;
    end else begin
      w_acc_sat  = DW'(r_acc);
      w_acc_clip = 1'b0;
    end
  end

  always_comb begin
    w_prod_clip = 1'b1;
    if (w_prod > PRD_MAX) begin
      w_vol_sat = OUT_MAX;
    end else if (w_prod < PRD_MIN) begin
      w_vol_sat = OUT_MIN;
    end else begin
      w_vol_sat   = DW'(w_prod);
      w_prod_clip = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_band      <= '0;
      r_acc       <= '0;
      r_frame_sat <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_sat   <= 1'b0;
      r_overrun   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_hold[c] <= '0;
        r_out[c]  <= '0;
      end
    end else begin
      r_out_vld <= 1'b0;
      r_out_sat <= 1'b0;
      r_overrun <= band_vld && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (band_vld) begin
            r_ch        <= '0;
            r_band      <= '0;
            r_acc       <= '0;
            r_frame_sat <= 1'b0;
          end
        end
        ST_MAC: begin
          r_acc  <= r_acc + w_prod_ext;
          r_band <= (r_band == LAST_BAND) ? '0 : r_band + BAND_W'(1);
        end
        ST_VOL: begin
          r_hold[r_ch] <= w_vol_sat;
          r_frame_sat  <= r_frame_sat | w_acc_clip | w_prod_clip;
          r_acc        <= '0;
          if (r_ch == LAST_CH) begin
            // Last channel bypasses its slot so out_smpl is complete on DONE entry.
            for (int c = 0; c < NUM_CH; c++) begin
              r_out[c] <= (c == NUM_CH - 1) ? w_vol_sat : r_hold[c];
            end
            r_out_vld <= 1'b1;
            r_out_sat <= r_frame_sat | w_acc_clip | w_prod_clip;
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_vld = r_out_vld;
  assign out_sat = r_out_sat;
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_eq_mix_engine.sv
// Self-checking bench for eq_mix_engine: table vectors, corner sequences and
// randomized frames on three parameterisations against an arithmetic model.
`timescale 1ns/1ps
module tb_eq_mix_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0;
  logic [2047:0] bs_all = '0;
  logic [191:0]  bg_all = '0;
  logic [11:0]   vol = '0;

  logic [31:0]  o_smpl0;
  logic [15:0]  o_smpl1;
  logic [127:0] o_smpl2;
  logic ov0, os0, bz0, or0;
  logic ov1, os1, bz1, or1;
  logic ov2, os2, bz2, or2;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int vc0 = 0, oc0 = 0;

  int     fx [8][16];
  int     fg [16];
  int     fvol;
  longint fexp [8];
  bit     fesat;

  eq_mix_engine #(.NUM_CH(2), .NUM_BANDS(5), .DW(16), .POT_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .band_vld(vld0), .band_smpl(bs_all[159:0]),
    .band_gain(bg_all[59:0]), .vol_gain(vol), .out_smpl(o_smpl0),
    .out_vld(ov0), .out_sat(os0), .busy(bz0), .overrun(or0));

  eq_mix_engine #(.NUM_CH(1), .NUM_BANDS(1), .DW(16), .POT_W(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .band_vld(vld1), .band_smpl(bs_all[15:0]),
    .band_gain(bg_all[11:0]), .vol_gain(vol), .out_smpl(o_smpl1),
    .out_vld(ov1), .out_sat(os1), .busy(bz1), .overrun(or1));

  eq_mix_engine #(.NUM_CH(8), .NUM_BANDS(16), .DW(16), .POT_W(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .band_vld(vld2), .band_smpl(bs_all),
    .band_gain(bg_all), .vol_gain(vol), .out_smpl(o_smpl2),
    .out_vld(ov2), .out_sat(os2), .busy(bz2), .overrun(or2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ov0) vc0 <= vc0 + 1;
    if (or0) oc0 <= oc0 + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint get_out(input int inst, input int c);
    logic signed [15:0] v;
    case (inst)
      0:       v = o_smpl0[c*16 +: 16];
      1:       v = o_smpl1;
      default: v = o_smpl2[c*16 +: 16];
    endcase
    return longint'(v);
  endfunction

  function automatic logic get_vld(input int inst);
    return (inst == 0) ? ov0 : (inst == 1) ? ov1 : ov2;
  endfunction

  function automatic logic get_sat(input int inst);
    return (inst == 0) ? os0 : (inst == 1) ? os1 : os2;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? bz0 : (inst == 1) ? bz1 : bz2;
  endfunction

  // Reference: floor(x*g/2048) per band, sum, clip, floor(sum*vol/2048), clip.
  task automatic model(input int nc, input int nb);
    longint acc;
    longint p;
    fesat = 1'b0;
    for (int c = 0; c < nc; c++) begin
      acc = 0;
      for (int b = 0; b < nb; b++)
        acc += (longint'(fx[c][b]) * longint'(fg[b])) >>> 11;
      if (acc > 32767) begin acc = 32767; fesat = 1'b1; end
      else if (acc < -32768) begin acc = -32768; fesat = 1'b1; end
      p = (acc * longint'(fvol)) >>> 11;
      if (p > 32767) begin p = 32767; fesat = 1'b1; end
      else if (p < -32768) begin p = -32768; fesat = 1'b1; end
      fexp[c] = p;
    end
  endtask

  task automatic drive(input int nb);
    bs_all = '0;
    bg_all = '0;
    for (int c = 0; c < 8; c++)
      for (int b = 0; b < nb; b++)
        bs_all[(c*nb+b)*16 +: 16] = 16'(fx[c][b]);
    for (int b = 0; b < nb; b++)
      bg_all[b*12 +: 12] = 12'(fg[b]);
    vol = 12'(fvol);
  endtask

  task automatic pulse(input int inst);
    case (inst)
      0:       vld0 = 1'b1;
      1:       vld1 = 1'b1;
      default: vld2 = 1'b1;
    endcase
    @(negedge clk);
    vld0 = 1'b0;
    vld1 = 1'b0;
    vld2 = 1'b0;
  endtask

  task automatic wait_check(input int inst, input int nc, input int nb,
                            input int t0, input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      @(negedge clk);
      if (get_vld(inst)) lat = cyc - t0;
    end
    chk({name, " latency"}, lat, nc * (nb + 1));
    if (lat >= 0) begin
      for (int c = 0; c < nc; c++)
        chk($sformatf("%s ch%0d", name, c), get_out(inst, c), fexp[c]);
      chk({name, " out_sat"}, longint'(get_sat(inst)), longint'(fesat));
      @(negedge clk);
      chk({name, " out_vld width"}, longint'(get_vld(inst)), 0);
      chk({name, " out_sat idle"}, longint'(get_sat(inst)), 0);
      chk({name, " busy after"}, longint'(get_busy(inst)), 0);
    end
    $display("frame %s inst=%0d lat=%0d ch0=%0d sat=%0d", name, inst, lat,
             get_out(inst, 0), fesat);
  endtask

  task automatic run_frame(input int inst, input int nc, input int nb,
                           input string name);
    int t0;
    drive(nb);
    pulse(inst);
    t0 = cyc;
    chk({name, " busy"}, longint'(get_busy(inst)), 1);
    wait_check(inst, nc, nb, t0, name);
  endtask

  task automatic rand_frame(input int nc, input int nb);
    int amp;
    case ($urandom_range(0, 2))
      0:       amp = 300;
      1:       amp = 8000;
      default: amp = 32767;
    endcase
    for (int c = 0; c < nc; c++)
      for (int b = 0; b < nb; b++)
        fx[c][b] = int'($urandom_range(0, 2 * amp)) - amp;
    for (int b = 0; b < nb; b++) fg[b] = int'($urandom_range(0, 4095));
    fvol = int'($urandom_range(0, 4095));
    model(nc, nb);
  endtask

  typedef struct {
    int x0b0; int x0r; int x1b0; int x1r;
    int g0; int gr; int vol;
    longint e0; longint e1; bit esat;
  } vec_t;

  vec_t tbl [8];

  task automatic load_vec(input vec_t v);
    for (int b = 0; b < 5; b++) begin
      fx[0][b] = (b == 0) ? v.x0b0 : v.x0r;
      fx[1][b] = (b == 0) ? v.x1b0 : v.x1r;
      fg[b]    = (b == 0) ? v.g0 : v.gr;
    end
    fvol    = v.vol;
    fexp[0] = v.e0;
    fexp[1] = v.e1;
    fesat   = v.esat;
  endtask

  initial begin
    int t0;
    int vc_before;
    int oc_before;

    tbl[0] = '{1000, 1000, -200, -200, 2048, 2048, 2048, 5000, -1000, 1'b0};
    tbl[1] = '{30000, 30000, -30000, -30000, 2048, 2048, 2048, 32767, -32768, 1'b1};
    tbl[2] = '{-1, 500, 3, 7, 1024, 0, 2048, -1, 1, 1'b0};
    tbl[3] = '{1000, 777, -1000, 777, 2048, 0, 4095, 1999, -2000, 1'b0};
    tbl[4] = '{5000, 5000, -100, -100, 2048, 2048, 4095, 32767, -1000, 1'b1};
    tbl[5] = '{12345, 12345, -4321, -4321, 0, 0, 0, 0, 0, 1'b0};
    tbl[6] = '{-32768, -32768, 32767, 32767, 4095, 4095, 1024, -16384, 16383, 1'b1};
    tbl[7] = '{100, 200, -3, -3, 2048, 1024, 2048, 500, -11, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset out_smpl", longint'(o_smpl0), 0);
    chk("reset out_vld", longint'(ov0), 0);
    chk("reset out_sat", longint'(os0), 0);
    chk("reset busy", longint'(bz0), 0);
    chk("reset overrun", longint'(or0), 0);
    chk("reset wide out_smpl", longint'(o_smpl2[63:0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      load_vec(tbl[i]);
      run_frame(0, 2, 5, $sformatf("vec%0d", i));
    end

    // Output holds between pulses
    repeat (5) @(negedge clk);
    chk("hold ch0", get_out(0, 0), tbl[7].e0);
    chk("hold ch1", get_out(0, 1), tbl[7].e1);
    chk("hold out_sat", longint'(os0), 0);

    // Second band_vld during a frame: dropped, flagged, first frame intact
    vc_before = vc0;
    oc_before = oc0;
    load_vec(tbl[0]);
    model(2, 5);
    drive(5);
    pulse(0);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      fx[0][b] = 3000;
      fx[1][b] = 3000;
      fg[b] = 4095;
    end
    fvol = 4095;
    drive(5);
    pulse(0);
    wait_check(0, 2, 5, t0, "overrun");
    repeat (20) @(negedge clk);
    chk("overrun pulses", longint'(oc0 - oc_before), 1);
    chk("overrun out_vld count", longint'(vc0 - vc_before), 1);

    // Reset in the middle of a frame
    load_vec(tbl[3]);
    drive(5);
    pulse(0);
    t0 = cyc;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_smpl", longint'(o_smpl0), 0);
    chk("midrst busy", longint'(bz0), 0);
    chk("midrst out_vld", longint'(ov0), 0);
    chk("midrst overrun", longint'(or0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vc_before = vc0;
    repeat (20) @(negedge clk);
    chk("midrst no out_vld", longint'(vc0 - vc_before), 0);
    chk("midrst out_smpl held 0", longint'(o_smpl0), 0);
    run_frame(0, 2, 5, "after_rst");

    // Randomized frames on all three parameterisations
    for (int i = 0; i < 20; i++) begin
      rand_frame(2, 5);
      run_frame(0, 2, 5, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      rand_frame(1, 1);
      run_frame(1, 1, 1, $sformatf("small%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      rand_frame(8, 16);
      run_frame(2, 8, 16, $sformatf("large%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
